// File: rtl/data_cache_refill_if.sv
// Bundle of the refill engine's pipeline, memory and cache-array signals.
// The engine side uses the master modport; the pipeline/memory/array environment uses slave.
interface data_cache_refill_if #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 5
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;

  logic                   miss_i;
  logic [31:2]            miss_addr_i;
  logic                   busy_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [31:2]            mem_req_addr_o;
  logic                   mem_rsp_valid_i;
  logic [31:0]            mem_rsp_data_i;
  logic [31:2]            cache_addr_o;
  logic [31:0]            cache_data_o;
  logic [3:0]             cache_wen_o;
  logic                   crit_valid_o;
  logic [31:0]            crit_data_o;
  logic                   tag_wen_o;
  logic [INDEX_WIDTH-1:0] tag_index_o;
  logic [TAG_WIDTH-1:0]   tag_o;
  logic                   fill_done_o;

  modport master (
    input  miss_i, miss_addr_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output busy_o, mem_req_valid_o, mem_req_addr_o, cache_addr_o, cache_data_o,
           cache_wen_o, crit_valid_o, crit_data_o, tag_wen_o, tag_index_o, tag_o,
           fill_done_o
  );

  modport slave (
    output miss_i, miss_addr_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  busy_o, mem_req_valid_o, mem_req_addr_o, cache_addr_o, cache_data_o,
           cache_wen_o, crit_valid_o, crit_data_o, tag_wen_o, tag_index_o, tag_o,
           fill_done_o
  );
endinterface

// File: rtl/data_cache_refill.sv
// Line-refill engine: requests a whole cache line on a miss, streams the beats into the
// data array, flags the missed word for early restart and commits the tag at the end.
module data_cache_refill #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 5
) (
  input logic                 clk_i,
  input logic                 rst_i,
  data_cache_refill_if.master bus
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [OFFSET_WIDTH-1:0] r_cnt;
  logic [OFFSET_WIDTH-1:0] r_crit_off;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [INDEX_WIDTH-1:0]  r_index;

  logic                    r_busy;
  logic                    r_req_valid;
  logic [31:2]             r_req_addr;
  logic [31:2]             r_cache_addr;
  logic [31:0]             r_cache_data;
  logic [3:0]              r_cache_wen;
  logic                    r_crit_valid;
  logic [31:0]             r_crit_data;
  logic                    r_tag_wen;
  logic                    r_fill_done;

  logic [TAG_WIDTH-1:0]    w_miss_tag;
  logic [INDEX_WIDTH-1:0]  w_miss_index;
  logic [OFFSET_WIDTH-1:0] w_miss_off;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_crit_beat;

  assign w_miss_tag   = bus.miss_addr_i[31 -: TAG_WIDTH];
  assign w_miss_index = bus.miss_addr_i[OFFSET_WIDTH+2 +: INDEX_WIDTH];
  assign w_miss_off   = bus.miss_addr_i[2 +: OFFSET_WIDTH];

  // Response beats only count while filling; there is no back-pressure on this channel.
  assign w_beat      = (r_state == S_FILL) && bus.mem_rsp_valid_i;
  assign w_last_beat = (r_cnt == {OFFSET_WIDTH{1'b1}});
  assign w_crit_beat = (r_cnt == r_crit_off);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_crit_off   <= '0;
      r_tag        <= '0;
      r_index      <= '0;
      r_busy       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_cache_wen  <= 4'h0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_tag_wen    <= 1'b0;
      r_fill_done  <= 1'b0;
    end else begin
      // Strobes last a single cycle unless re-armed below.
      r_cache_wen  <= 4'h0;
      r_crit_valid <= 1'b0;
      r_tag_wen    <= 1'b0;
      r_fill_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.miss_i) begin
            r_tag       <= w_miss_tag;
            r_index     <= w_miss_index;
            r_crit_off  <= w_miss_off;
            r_cnt       <= '0;
            r_req_addr  <= {w_miss_tag, w_miss_index, {OFFSET_WIDTH{1'b0}}};
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus.mem_req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_beat) begin
            r_cache_addr <= {r_tag, r_index, r_cnt};
            r_cache_data <= bus.mem_rsp_data_i;
            r_cache_wen  <= 4'hF;
            if (w_crit_beat) begin
              r_crit_valid <= 1'b1;
              r_crit_data  <= bus.mem_rsp_data_i;
            end
            r_cnt <= r_cnt + CNT_ONE;
            // Tag commit lands in the same cycle as the final data write.
            if (w_last_beat) begin
              r_tag_wen   <= 1'b1;
              r_fill_done <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy      <= 1'b0;
          r_req_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o          = r_busy;
  assign bus.mem_req_valid_o = r_req_valid;
  assign bus.mem_req_addr_o  = r_req_addr;
  assign bus.cache_addr_o    = r_cache_addr;
  assign bus.cache_data_o    = r_cache_data;
  assign bus.cache_wen_o     = r_cache_wen;
  assign bus.crit_valid_o    = r_crit_valid;
  assign bus.crit_data_o     = r_crit_data;
  assign bus.tag_wen_o       = r_tag_wen;
  assign bus.tag_index_o     = r_index;
  assign bus.tag_o           = r_tag;
  assign bus.fill_done_o     = r_fill_done;

endmodule

// File: tb/tb_data_cache_refill.sv
// Scoreboard bench for data_cache_refill: default geometry plus a 2/2-bit geometry instance.
module tb_data_cache_refill;
  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    bit          crit;
    bit          last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  data_cache_refill_if #(.INDEX_WIDTH(4), .OFFSET_WIDTH(5)) ifa ();
  data_cache_refill_if #(.INDEX_WIDTH(2), .OFFSET_WIDTH(2)) ifb ();

  data_cache_refill #(.INDEX_WIDTH(4), .OFFSET_WIDTH(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa)
  );
  data_cache_refill #(.INDEX_WIDTH(2), .OFFSET_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic score(input int sel, input logic [3:0] wen, input logic [29:0] addr,
                       input logic [31:0] data, input logic cv, input logic [31:0] cd,
                       input logic tw, input logic fd);
    exp_t e;
    if (wen == 4'h0) begin
      if (cv || tw || fd) begin
        checks++;
        errors++;
        $display("FAIL dut%0d pulse_without_write: crit=%b tag_wen=%b done=%b, required 000",
                 sel, cv, tw, fd);
      end
      return;
    end
    if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_write: addr=%h data=%h, required no write", sel, addr, data);
      return;
    end
    if (sel == 0) e = qa.pop_front();
    else          e = qb.pop_front();
    $display("dut%0d write addr=%h data=%h crit=%b commit=%b", sel, addr, data, cv, tw);
    chk("wr_wen",    64'(wen),  64'(4'hF));
    chk("wr_addr",   64'(addr), 64'(e.addr));
    chk("wr_data",   64'(data), 64'(e.data));
    chk("crit_vld",  64'(cv),   64'(e.crit));
    if (e.crit) chk("crit_data", 64'(cd), 64'(e.data));
    chk("tag_wen",   64'(tw),   64'(e.last));
    chk("fill_done", 64'(fd),   64'(e.last));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      score(0, ifa.cache_wen_o, ifa.cache_addr_o, ifa.cache_data_o, ifa.crit_valid_o,
            ifa.crit_data_o, ifa.tag_wen_o, ifa.fill_done_o);
      score(1, ifb.cache_wen_o, ifb.cache_addr_o, ifb.cache_data_o, ifb.crit_valid_o,
            ifb.crit_data_o, ifb.tag_wen_o, ifb.fill_done_o);
    end
  end

  // Called just after a negedge; leaves the engine in REQ.
  task automatic start_miss_a(input logic [29:0] addr, input logic [29:0] base,
                              input logic [20:0] tag, input logic [3:0] idx, input logic rdy);
    ifa.miss_i          = 1'b1;
    ifa.miss_addr_i     = addr;
    ifa.mem_req_ready_i = rdy;
    @(negedge clk);
    ifa.miss_i = 1'b0;
    chk("req_busy",  64'(ifa.busy_o),          64'(1));
    chk("req_valid", 64'(ifa.mem_req_valid_o), 64'(1));
    chk("req_addr",  64'(ifa.mem_req_addr_o),  64'(base));
    chk("req_tag",   64'(ifa.tag_o),           64'(tag));
    chk("req_index", 64'(ifa.tag_index_o),     64'(idx));
  endtask

  task automatic fill_a(input logic [29:0] base, input int crit, input int first, input int last,
                        input logic [31:0] dbase, input int gap);
    for (int k = first; k <= last; k++) begin
      ifa.mem_rsp_valid_i = 1'b1;
      ifa.mem_rsp_data_i  = dbase + 32'(k);
      qa.push_back('{addr: base | 30'(k), data: dbase + 32'(k), crit: (k == crit), last: (k == 31)});
      @(negedge clk);
      ifa.mem_rsp_valid_i = 1'b0;
      ifa.mem_rsp_data_i  = 32'h0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic finish_a(input string name);
    chk({name, "_busy_done"}, 64'(ifa.busy_o), 64'(1));
    @(negedge clk);
    chk({name, "_busy_idle"}, 64'(ifa.busy_o), 64'(0));
    chk({name, "_sb_empty"},  64'(qa.size()),  64'(0));
  endtask

  initial begin
    rst = 1'b1;
    ifa.miss_i = 1'b0; ifa.miss_addr_i = '0; ifa.mem_req_ready_i = 1'b0;
    ifa.mem_rsp_valid_i = 1'b0; ifa.mem_rsp_data_i = '0;
    ifb.miss_i = 1'b0; ifb.miss_addr_i = '0; ifb.mem_req_ready_i = 1'b0;
    ifb.mem_rsp_valid_i = 1'b0; ifb.mem_rsp_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_busy",  64'(ifa.busy_o), 64'(0));
    chk("rst_a_outs",  64'(|{ifa.mem_req_valid_o, ifa.mem_req_addr_o, ifa.cache_addr_o,
                             ifa.cache_data_o, ifa.cache_wen_o, ifa.crit_valid_o, ifa.crit_data_o,
                             ifa.tag_wen_o, ifa.tag_index_o, ifa.tag_o, ifa.fill_done_o}), 64'(0));
    chk("rst_b_outs",  64'(|{ifb.busy_o, ifb.mem_req_valid_o, ifb.cache_wen_o, ifb.tag_o}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic fill: critical word at offset 30.
    start_miss_a(30'h048D159E, 30'h048D1580, 21'h2468A, 4'hC, 1'b1);
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    chk("basic_req_drop", 64'(ifa.mem_req_valid_o), 64'(0));
    fill_a(30'h048D1580, 30, 0, 31, 32'hA000_0000, 0);
    finish_a("basic");

    // Request back-pressure with stray beats during REQ.
    start_miss_a(30'h15555555, 30'h15555540, 21'h0AAAAA, 4'hA, 1'b0);
    for (int c = 0; c < 5; c++) begin
      ifa.mem_rsp_valid_i = 1'b1;
      ifa.mem_rsp_data_i  = 32'hDEAD_0000 + 32'(c);
      @(negedge clk);
      chk("bp_valid", 64'(ifa.mem_req_valid_o), 64'(1));
      chk("bp_addr",  64'(ifa.mem_req_addr_o),  64'(30'h15555540));
    end
    ifa.mem_rsp_valid_i = 1'b0;
    ifa.mem_req_ready_i = 1'b1;
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    chk("bp_req_drop", 64'(ifa.mem_req_valid_o), 64'(0));
    fill_a(30'h15555540, 21, 0, 31, 32'hB000_0000, 0);
    finish_a("bp");

    // Gapped beats: one accepted beat, then two idle cycles.
    start_miss_a(30'h20000007, 30'h20000000, 21'h100000, 4'h0, 1'b1);
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    fill_a(30'h20000000, 7, 0, 30, 32'hC0DE_0000, 2);
    chk("gap_not_done", 64'(ifa.busy_o), 64'(1));
    fill_a(30'h20000000, 7, 31, 31, 32'hC0DE_0000, 0);
    finish_a("gap");

    // Miss while busy is ignored and not remembered.
    start_miss_a(30'h0ABCDE21, 30'h0ABCDE20, 21'h055E6F, 4'h1, 1'b1);
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    fill_a(30'h0ABCDE20, 1, 0, 5, 32'h1111_0000, 0);
    ifa.miss_i = 1'b1;
    ifa.miss_addr_i = 30'h3FFFFFFF;
    @(negedge clk);
    ifa.miss_i = 1'b0;
    chk("mwb_tag",   64'(ifa.tag_o),           64'(21'h055E6F));
    chk("mwb_index", 64'(ifa.tag_index_o),     64'(4'h1));
    chk("mwb_noreq", 64'(ifa.mem_req_valid_o), 64'(0));
    fill_a(30'h0ABCDE20, 1, 6, 31, 32'h1111_0000, 0);
    finish_a("mwb");
    repeat (3) begin
      @(negedge clk);
      chk("mwb_idle_noreq", 64'(ifa.mem_req_valid_o | ifa.busy_o), 64'(0));
    end

    // Reset after beat 10; nothing is committed and the next fill restarts at offset 0.
    start_miss_a(30'h01234567, 30'h01234560, 21'h0091A2, 4'hB, 1'b1);
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    fill_a(30'h01234560, 7, 0, 10, 32'hD000_0000, 0);
    #2;
    rst = 1'b1;
    ifa.mem_rsp_valid_i = 1'b1;
    ifa.mem_rsp_data_i  = 32'hBAD0_BAD0;
    #1;
    chk("arst_busy", 64'(ifa.busy_o), 64'(0));
    chk("arst_outs", 64'(|{ifa.mem_req_valid_o, ifa.mem_req_addr_o, ifa.cache_addr_o,
                           ifa.cache_data_o, ifa.cache_wen_o, ifa.crit_valid_o, ifa.crit_data_o,
                           ifa.tag_wen_o, ifa.tag_index_o, ifa.tag_o, ifa.fill_done_o}), 64'(0));
    repeat (2) @(negedge clk);
    chk("arst_no_commit", 64'(ifa.tag_wen_o), 64'(0));
    rst = 1'b0;
    ifa.mem_rsp_valid_i = 1'b0;
    chk("arst_sb_empty", 64'(qa.size()), 64'(0));
    @(negedge clk);
    start_miss_a(30'h01234567, 30'h01234560, 21'h0091A2, 4'hB, 1'b1);
    @(negedge clk);
    ifa.mem_req_ready_i = 1'b0;
    fill_a(30'h01234560, 7, 0, 31, 32'hE000_0000, 0);
    finish_a("restart");

    // Small geometry: critical word at offset 0, commit after 4 beats.
    ifb.miss_i = 1'b1;
    ifb.miss_addr_i = 30'h12345678;
    ifb.mem_req_ready_i = 1'b1;
    @(negedge clk);
    ifb.miss_i = 1'b0;
    chk("b_req_addr", 64'(ifb.mem_req_addr_o), 64'(30'h12345678));
    chk("b_tag",      64'(ifb.tag_o),          64'(26'h1234567));
    chk("b_index",    64'(ifb.tag_index_o),    64'(2'h2));
    @(negedge clk);
    ifb.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifb.mem_rsp_valid_i = 1'b1;
      ifb.mem_rsp_data_i  = 32'hF000_0000 + 32'(k);
      qb.push_back('{addr: 30'h12345678 | 30'(k), data: 32'hF000_0000 + 32'(k),
                     crit: (k == 0), last: (k == 3)});
      @(negedge clk);
    end
    ifb.mem_rsp_valid_i = 1'b0;
    chk("b_busy_done", 64'(ifb.busy_o), 64'(1));
    @(negedge clk);
    chk("b_busy_idle", 64'(ifb.busy_o), 64'(0));
    chk("b_sb_empty",  64'(qb.size()),  64'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
